// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - filled-rectangle command to raster-order framebuffer pixel writes
module rect_fill_engine #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y),
  localparam int CW = $clog2(PALETTE_LENGTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [XW-1:0] cmd_x0_i,
  input  logic [XW-1:0] cmd_x1_i,
  input  logic [YW-1:0] cmd_y0_i,
  input  logic [YW-1:0] cmd_y1_i,
  input  logic [CW-1:0] cmd_palette_index_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          we_o,
  output logic [XW-1:0] wr_pxl_x_o,
  output logic [YW-1:0] wr_pxl_y_o,
  output logic [CW-1:0] wr_palette_index_o
);

  localparam logic [XW-1:0] X_LAST = XW'(RESOLUTION_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(RESOLUTION_Y - 1);

  typedef enum logic [1:0] {IDLE, FILL, SKIP} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] y_q, y_d, ymax_q, ymax_d;
  logic [CW-1:0] col_q, col_d;

  logic          ready_d, busy_d, done_d, we_d;
  logic [XW-1:0] wx_d;
  logic [YW-1:0] wy_d;
  logic [CW-1:0] wc_d;

  logic [XW-1:0] lo_x, hi_x, hi_x_clip, nx;
  logic [YW-1:0] lo_y, hi_y, hi_y_clip, ny;
  logic          at_last;

  // Normalised and clipped corners of the incoming command.
  always_comb begin
    lo_x      = (cmd_x0_i < cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
    hi_x      = (cmd_x0_i < cmd_x1_i) ? cmd_x1_i : cmd_x0_i;
    lo_y      = (cmd_y0_i < cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
    hi_y      = (cmd_y0_i < cmd_y1_i) ? cmd_y1_i : cmd_y0_i;
    hi_x_clip = (hi_x > X_LAST) ? X_LAST : hi_x;
    hi_y_clip = (hi_y > Y_LAST) ? Y_LAST : hi_y;
  end

  // Raster step from the pixel currently on the write port.
  always_comb begin
    at_last = (x_q == xmax_q) && (y_q == ymax_q);
    if (x_q == xmax_q) begin
      nx = xmin_q;
      ny = y_q + YW'(1);
    end else begin
      nx = x_q + XW'(1);
      ny = y_q;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    col_d   = col_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    wx_d    = '0;
    wy_d    = '0;
    wc_d    = '0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_o) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          xmin_d  = lo_x;
          xmax_d  = hi_x_clip;
          ymax_d  = hi_y_clip;
          col_d   = cmd_palette_index_i;
          if (lo_x > X_LAST || lo_y > Y_LAST) begin
            state_d = SKIP;
            done_d  = 1'b1;
          end else begin
            // First pixel goes out on the accept edge itself.
            state_d = FILL;
            x_d     = lo_x;
            y_d     = lo_y;
            we_d    = 1'b1;
            wx_d    = lo_x;
            wy_d    = lo_y;
            wc_d    = cmd_palette_index_i;
            done_d  = (lo_x == hi_x_clip) && (lo_y == hi_y_clip);
          end
        end
      end
      FILL: begin
        if (at_last) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          x_d    = nx;
          y_d    = ny;
          we_d   = 1'b1;
          wx_d   = nx;
          wy_d   = ny;
          wc_d   = col_q;
          done_d = (nx == xmax_q) && (ny == ymax_q);
        end
      end
      SKIP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q            <= IDLE;
      x_q                <= '0;
      y_q                <= '0;
      xmin_q             <= '0;
      xmax_q             <= '0;
      ymax_q             <= '0;
      col_q              <= '0;
      cmd_ready_o        <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      we_o               <= 1'b0;
      wr_pxl_x_o         <= '0;
      wr_pxl_y_o         <= '0;
      wr_palette_index_o <= '0;
    end else begin
      state_q            <= state_d;
      x_q                <= x_d;
      y_q                <= y_d;
      xmin_q             <= xmin_d;
      xmax_q             <= xmax_d;
      ymax_q             <= ymax_d;
      col_q              <= col_d;
      cmd_ready_o        <= ready_d;
      busy_o             <= busy_d;
      done_o             <= done_d;
      we_o               <= we_d;
      wr_pxl_x_o         <= wx_d;
      wr_pxl_y_o         <= wy_d;
      wr_palette_index_o <= wc_d;
    end
  end

endmodule
